// File: rtl/multi_channel_counter.sv
// Bank of independent up/down counters with load, terminal-count pulse and optional
// coherent snapshot (enabled by defining COUNTER_SNAPSHOT_EN).
module multi_channel_counter #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       up_dn,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    input  logic                      snap_req,
    output logic [CHANNELS*WIDTH-1:0] snap_data,
    output logic                      snap_valid
);

    localparam logic [WIDTH-1:0] MaxVal = '1;

    // Channel k comes out of reset holding k, so channels are distinguishable at power-up.
    function automatic logic [CHANNELS*WIDTH-1:0] reset_counts();
        logic [CHANNELS*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            r[k*WIDTH +: WIDTH] = WIDTH'(k);
        end
        return r;
    endfunction

    localparam logic [CHANNELS*WIDTH-1:0] CountRst = reset_counts();

    logic [CHANNELS*WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]       tc_q, tc_d;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        logic             term;
        logic             tc_nxt;

        assign cur  = count_q[k*WIDTH +: WIDTH];
        assign term = up_dn[k] ? (cur == MaxVal) : (cur == '0);

        always_comb begin
            nxt    = cur;
            tc_nxt = 1'b0;
            if (load[k]) begin
                nxt = load_val[k*WIDTH +: WIDTH];
            end else if (en[k]) begin
                tc_nxt = term;
                if (!((SATURATE != 0) && term)) begin
                    nxt = up_dn[k] ? cur + WIDTH'(1) : cur - WIDTH'(1);
                end
            end
        end

        assign count_d[k*WIDTH +: WIDTH] = nxt;
        assign tc_d[k]                   = tc_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= CountRst;
            tc_q    <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

`ifdef COUNTER_SNAPSHOT_EN
    logic [CHANNELS*WIDTH-1:0] snap_data_q, snap_data_d;
    logic                      snap_valid_q, snap_valid_d;

    // Capture pre-edge counts of every channel together so the snapshot is coherent.
    always_comb begin
        snap_data_d  = snap_req ? count_q : snap_data_q;
        snap_valid_d = snap_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_data_q  <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_data_q  <= snap_data_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign snap_data  = snap_data_q;
    assign snap_valid = snap_valid_q;
`else
    logic unused_snap_req;
    assign unused_snap_req = snap_req;
    assign snap_data       = '0;
    assign snap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_multi_channel_counter.sv
// Scoreboard bench for multi_channel_counter: one wrapping and one saturating instance
// driven by the same directed vectors; a monitor pops expected outputs every cycle.
module tb_multi_channel_counter;

    localparam int W  = 5;
    localparam int CH = 2;
`ifdef COUNTER_SNAPSHOT_EN
    localparam bit SnapEn = 1'b1;
`else
    localparam bit SnapEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    en = '0, up_dn = '0, load = '0;
    logic [9:0]    load_val = '0;
    logic          snap_req = 1'b0;

    logic [9:0]    cnt_w, sd_w, cnt_s, sd_s;
    logic [1:0]    tc_w, tc_s;
    logic          sv_w, sv_s;

    always #5 clk = ~clk;

    multi_channel_counter #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(cnt_w), .tc(tc_w), .snap_req(snap_req), .snap_data(sd_w), .snap_valid(sv_w)
    );

    multi_channel_counter #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(cnt_s), .tc(tc_s), .snap_req(snap_req), .snap_data(sd_s), .snap_valid(sv_s)
    );

    typedef struct packed {
        logic [9:0] cnt_w;
        logic [9:0] cnt_s;
        logic [1:0] tc_w;
        logic [1:0] tc_s;
        logic [9:0] sd_w;
        logic [9:0] sd_s;
        logic       sv_w;
        logic       sv_s;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state, index 0 = wrapping instance, 1 = saturating instance.
    logic [9:0] m_cnt [2];
    logic [1:0] m_tc  [2];
    logic [9:0] m_sd  [2];
    logic       m_sv  [2];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = {5'd1, 5'd0};
            m_tc[d]  = 2'b00;
            m_sd[d]  = '0;
            m_sv[d]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic [1:0] e, input logic [1:0] u, input logic [1:0] l,
                              input logic [9:0] lv, input logic s);
        for (int d = 0; d < 2; d++) begin
            logic [9:0] pre;
            pre = m_cnt[d];
            m_sv[d] = SnapEn & s;
            if (SnapEn && s) m_sd[d] = pre;
            for (int k = 0; k < 2; k++) begin
                logic [4:0] c;
                c = pre[k*5 +: 5];
                m_tc[d][k] = 1'b0;
                if (l[k]) begin
                    c = lv[k*5 +: 5];
                end else if (e[k]) begin
                    if (u[k]) begin
                        if (c == 5'd31) begin
                            m_tc[d][k] = 1'b1;
                            if (d == 0) c = 5'd0;
                        end else c = c + 5'd1;
                    end else begin
                        if (c == 5'd0) begin
                            m_tc[d][k] = 1'b1;
                            if (d == 0) c = 5'd31;
                        end else c = c - 5'd1;
                    end
                end
                m_cnt[d][k*5 +: 5] = c;
            end
        end
    endtask

    task automatic step(input logic [1:0] e, input logic [1:0] u, input logic [1:0] l,
                        input logic [9:0] lv, input logic s);
        exp_t x;
        @(negedge clk);
        en = e; up_dn = u; load = l; load_val = lv; snap_req = s;
        model_step(e, u, l, lv, s);
        x.cnt_w = m_cnt[0]; x.cnt_s = m_cnt[1];
        x.tc_w  = m_tc[0];  x.tc_s  = m_tc[1];
        x.sd_w  = m_sd[0];  x.sd_s  = m_sd[1];
        x.sv_w  = m_sv[0];  x.sv_s  = m_sv[1];
        sb_q.push_back(x);
        @(posedge clk);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            check("sb_count_wrap", cnt_w, mon_x.cnt_w);
            check("sb_count_sat",  cnt_s, mon_x.cnt_s);
            check("sb_tc_wrap",    tc_w,  mon_x.tc_w);
            check("sb_tc_sat",     tc_s,  mon_x.tc_s);
            check("sb_snap_data_wrap",  sd_w, mon_x.sd_w);
            check("sb_snap_data_sat",   sd_s, mon_x.sd_s);
            check("sb_snap_valid_wrap", sv_w, mon_x.sv_w);
            check("sb_snap_valid_sat",  sv_s, mon_x.sv_s);
        end
    end

    int tc0_n, tc1_n;

    initial begin
        model_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_count",      cnt_w, {5'd1, 5'd0});
        check("rst_count_sat",  cnt_s, {5'd1, 5'd0});
        check("rst_tc",         tc_w, 2'b00);
        check("rst_snap_data",  sd_w, 10'd0);
        check("rst_snap_valid", sv_w, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Free-run up for 32 edges from reset values.
        tc0_n = 0;
        tc1_n = 0;
        for (int i = 0; i < 32; i++) begin
            step(2'b11, 2'b11, 2'b00, 10'd0, 1'b0);
            #1;
            if (tc_w[0] === 1'b1) tc0_n++;
            if (tc_w[1] === 1'b1) tc1_n++;
        end
        check("run32_tc0_pulses", tc0_n, 1);
        check("run32_tc1_pulses", tc1_n, 1);
        check("run32_count", cnt_w, {5'd1, 5'd0});
        check("run32_tc", tc_w, 2'b01);
        check("run32_count_sat", cnt_s, {5'd31, 5'd31});
        check("run32_tc_sat", tc_s, 2'b11);

        // Down from 0 on ch0.
        step(2'b00, 2'b00, 2'b01, 10'd0, 1'b0);
        step(2'b01, 2'b00, 2'b00, 10'd0, 1'b0);
        #1;
        check("down0_wrap_count", cnt_w[4:0], 5'd31);
        check("down0_wrap_tc", tc_w[0], 1'b1);
        check("down0_sat_count", cnt_s[4:0], 5'd0);
        check("down0_sat_tc", tc_s[0], 1'b1);
        step(2'b01, 2'b00, 2'b00, 10'd0, 1'b0);
        #1;
        check("down0b_wrap_count", cnt_w[4:0], 5'd30);
        check("down0b_wrap_tc", tc_w[0], 1'b0);
        check("down0b_sat_count", cnt_s[4:0], 5'd0);
        check("down0b_sat_tc", tc_s[0], 1'b1);

        // Load beats enable on ch1.
        step(2'b10, 2'b10, 2'b10, {5'd17, 5'd0}, 1'b0);
        #1;
        check("load17_count", cnt_w[9:5], 5'd17);
        check("load17_tc", tc_w[1], 1'b0);
        check("load17_count_sat", cnt_s[9:5], 5'd17);
        step(2'b10, 2'b10, 2'b00, 10'd0, 1'b0);
        #1;
        check("load17_next", cnt_w[9:5], 5'd18);
        step(2'b10, 2'b10, 2'b00, 10'd0, 1'b0);
        step(2'b10, 2'b00, 2'b00, 10'd0, 1'b0);
        #1;
        check("dir_change", cnt_w[9:5], 5'd18);
        step(2'b10, 2'b10, 2'b10, {5'd31, 5'd0}, 1'b0);
        step(2'b10, 2'b10, 2'b00, 10'd0, 1'b0);
        #1;
        check("up31_wrap_count", cnt_w[9:5], 5'd0);
        check("up31_wrap_tc", tc_w[1], 1'b1);
        check("up31_sat_count", cnt_s[9:5], 5'd31);

        // Asynchronous reset between edges with a load and snapshot pending.
        step(2'b01, 2'b00, 2'b01, {5'd0, 5'd12}, 1'b0);
        #3;
        en = 2'b11; up_dn = 2'b11; load = 2'b11; load_val = {5'd9, 5'd9}; snap_req = 1'b1;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_count", cnt_w, {5'd1, 5'd0});
        check("async_rst_count_sat", cnt_s, {5'd1, 5'd0});
        check("async_rst_tc", tc_w, 2'b00);
        check("async_rst_snap_valid", sv_w, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held_count", cnt_w, {5'd1, 5'd0});
        @(negedge clk);
        en = '0; up_dn = '0; load = '0; load_val = '0; snap_req = 1'b0;
        reset = 1'b0;
        step(2'b11, 2'b11, 2'b00, 10'd0, 1'b0);
        #1;
        check("post_rst_first", cnt_w, {5'd2, 5'd1});

        // Snapshot with ch0=7, ch1=20.
        step(2'b00, 2'b00, 2'b11, {5'd20, 5'd7}, 1'b0);
        step(2'b11, 2'b11, 2'b00, 10'd0, 1'b1);
        #1;
        check("snap_counts", cnt_w, {5'd21, 5'd8});
        check("snap_data", sd_w, SnapEn ? {5'd20, 5'd7} : 10'd0);
        check("snap_valid", sv_w, SnapEn);
        step(2'b11, 2'b11, 2'b00, 10'd0, 1'b0);
        #1;
        check("snap_valid_drop", sv_w, 1'b0);
        check("snap_data_hold", sd_w, SnapEn ? {5'd20, 5'd7} : 10'd0);

        // Dual rate: ch0 enabled every other cycle, ch1 always.
        for (int i = 0; i < 64; i++) begin
            step({1'b1, i[0]}, 2'b11, 2'b00, 10'd0, 1'b0);
        end
        #1;
        check("dual_rate_count", cnt_w, {5'd22, 5'd9});
        check("dual_rate_count_sat", cnt_s, {5'd31, 5'd31});

        repeat (2) @(posedge clk);
        #2;
        check("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_counter.md
MULTI_CHANNEL_COUNTER -- requirements
Module: multi_channel_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the counter width in bits per channel (range 2..32).
REQ-002 SHALL have parameter CHANNELS, default 2, giving the number of independent counter channels (range 1..16).
REQ-003 SHALL have parameter SATURATE, default 0: 0 wraps at the limits, 1 holds at the limits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, CHANNELS bits: per-channel count enable.
REQ-007 SHALL have port up_dn, input, CHANNELS bits: per-channel direction, 1=up, 0=down.
REQ-008 SHALL have port load, input, CHANNELS bits: per-channel synchronous load strobe.
REQ-009 SHALL have port load_val, input, CHANNELS*WIDTH bits: channel k value in bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port count, output, CHANNELS*WIDTH bits: registered per-channel count, packed the same way as load_val.
REQ-011 SHALL have port tc, output, CHANNELS bits: registered per-channel terminal-count pulse.
REQ-012 SHALL have port snap_req, input, 1 bit: snapshot request.
REQ-013 SHALL have port snap_data, output, CHANNELS*WIDTH bits: coherent snapshot of all channels.
REQ-014 SHALL have port snap_valid, output, 1 bit: snapshot-valid pulse.

Function
REQ-015 Channels SHALL be fully independent; per-channel priority at each edge: load > en > hold.
REQ-016 When load[k]=1, count[k] SHALL take load_val[k] at the edge, regardless of en[k]; tc[k]=0 next cycle.
REQ-017 When en[k]=1 and up_dn[k]=1, count[k] SHALL become count+1 mod 2^WIDTH; when up_dn[k]=0, count-1 mod 2^WIDTH.
REQ-018 When SATURATE=1, an up step at 2^WIDTH-1 or a down step at 0 SHALL leave count[k] unchanged.
REQ-019 tc[k] SHALL be 1 for exactly the cycle after an enabled, non-load edge whose pre-edge count was terminal (2^WIDTH-1 for up, 0 for down); otherwise 0.
REQ-020 A held terminal condition (saturating, en held) SHALL assert tc[k] every enabled cycle.
REQ-021 Count latency SHALL be one edge: a value sampled on edge N is visible on count after edge N.
REQ-022 A direction change SHALL take effect on the same edge it is sampled, with no idle cycle.

Reset
REQ-023 While reset=1, count[k] SHALL be k mod 2^WIDTH (ch0=0, ch1=1), tc=0, snap_data=0 and snap_valid=0, asynchronously.
REQ-024 A reset asserted mid-count SHALL discard any pending load or snapshot; the first update SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro COUNTER_SNAPSHOT_EN SHALL control the snapshot feature.
REQ-026 With COUNTER_SNAPSHOT_EN defined: snap_req=1 at edge N SHALL capture the pre-edge-N count of all channels into snap_data, and snap_valid SHALL be 1 for the following cycle.
REQ-027 With COUNTER_SNAPSHOT_EN defined: snap_data SHALL hold its value until the next capture, and snap_req held high SHALL capture on every edge.
REQ-028 Without COUNTER_SNAPSHOT_EN: the snapshot ports SHALL remain present, snap_data and snap_valid SHALL be tied 0, and snap_req SHALL be ignored.

Verification (WIDTH=5, CHANNELS=2)
REQ-029 Release reset with en=2'b11 and up_dn=2'b11, run 32 edges -> ch0 runs 0..31, 0; ch1 runs 1..31, 0, 1; tc[0] pulses once after 31->0; tc[1] pulses once after 31->0.
REQ-030 ch0 down from 0 with SATURATE=0 -> count 31 and tc[0]=1 next cycle; with SATURATE=1 -> count stays 0 and tc[0]=1 each enabled cycle.
REQ-031 load[1]=1, load_val ch1=17 and en[1]=1 on the same edge -> count ch1=17, tc[1]=0; next edge -> 18.
REQ-032 Assert reset asynchronously between edges with ch0=12 -> count ch0=0 immediately, without waiting for an edge; tc and snap_valid=0.
REQ-033 COUNTER_SNAPSHOT_EN defined, ch0=7, ch1=20, snap_req pulse -> snap_data {20,7} and snap_valid=1 for one cycle while the counts advance to 8 and 21.
REQ-034 Dual-rate check: en[0] toggled every other cycle and en[1] held 1 for 64 cycles -> ch0 advances 32 and ch1 advances 64, matching a reference model, with zero mismatches.
